// File: rtl/mem_pkg.sv
// Shared opcode/state types and decode helpers for the load/store unit.
package mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LB   = 4'd0,
    OP_LH   = 4'd1,
    OP_LW   = 4'd2,
    OP_LBU  = 4'd3,
    OP_LHU  = 4'd4,
    OP_SB   = 4'd5,
    OP_SH   = 4'd6,
    OP_SW   = 4'd7,
    OP_NONE = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Codes above SW (NONE and unused encodings) are treated as non-memory.
  function automatic logic is_mem_op(input mem_op_e op);
    return op < OP_NONE;
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_e op_size(input mem_op_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    case (op_size(op))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication and load extract/extend.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  mem_op_e                         op_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off_i,
  input  logic [XLEN-1:0]                 wdata_i,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  output logic [DATA_WIDTH/8-1:0]         be_o,
  output logic [DATA_WIDTH-1:0]           wdata_o,
  output logic [XLEN-1:0]                 rdata_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  logic [XLEN-1:0] word_sel;
  logic [XLEN-1:0] lane_word;

  // Pick the 32-bit word holding the access, then shift the addressed byte to bit 0.
  if (BE_W == 4) begin : g_word
    assign word_sel = rdata_i;
  end else begin : g_dword
    assign word_sel = off_i[OFF_W-1] ? rdata_i[DATA_WIDTH-1 -: XLEN] : rdata_i[XLEN-1:0];
  end

  assign lane_word = word_sel >> {off_i[1:0], 3'b000};

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (op_size(op_i))
      SZ_HALF: begin
        be_o    = BE_W'(4'b0011) << off_i;
        wdata_o = {(DATA_WIDTH/16){wdata_i[15:0]}};
      end
      SZ_WORD: begin
        be_o    = BE_W'(4'b1111) << off_i;
        wdata_o = {(DATA_WIDTH/32){wdata_i}};
      end
      default: begin
        be_o    = BE_W'(4'b0001) << off_i;
        wdata_o = {(DATA_WIDTH/8){wdata_i[7:0]}};
      end
    endcase
  end

  always_comb begin
    rdata_o = '0;
    case (op_i)
      OP_LB:   rdata_o = {{24{lane_word[7]}}, lane_word[7:0]};
      OP_LH:   rdata_o = {{16{lane_word[15]}}, lane_word[15:0]};
      OP_LW:   rdata_o = lane_word;
      OP_LBU:  rdata_o = {24'd0, lane_word[7:0]};
      OP_LHU:  rdata_o = {16'd0, lane_word[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between EXE/MEM and MEM/WB: req/gnt/rvalid RAM port with
// stall, alignment check and response timeout.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RADDR_WIDTH    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  input  logic [OP_W-1:0]         mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]         mem_data_i,
  input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [XLEN-1:0]         reg_wdata_i,
  output logic                    stall_o,
  output logic                    ram_req_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic                    ram_gnt_i,
  input  logic                    ram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    wb_valid_o,
  output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
  output logic                    reg_we_o,
  output logic [XLEN-1:0]         reg_wdata_o,
  output logic                    misalign_o,
  output logic                    bus_err_o,
  output logic [ADDR_WIDTH-1:0]   fault_addr_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  mem_op_e                op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   rwe_q, rwe_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   wb_valid_q, wb_valid_d;
  logic [RADDR_WIDTH-1:0] wb_waddr_q, wb_waddr_d;
  logic                   wb_we_q, wb_we_d;
  logic [XLEN-1:0]        wb_wdata_q, wb_wdata_d;
  logic                   misalign_q, misalign_d;
  logic                   bus_err_q, bus_err_d;
  logic [ADDR_WIDTH-1:0]  fault_addr_q, fault_addr_d;

  mem_op_e           op_in;
  logic              in_mem, in_misal, accept_c;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [XLEN-1:0]   load_data;

  assign op_in    = mem_op_e'(mem_op_i);
  assign in_mem   = is_mem_op(op_in);
  assign in_misal = is_misaligned(op_in, mem_addr_i[1:0]);
  // Gated by reset so a held valid_i cannot re-raise stall while in reset.
  assign accept_c = rst_n_i && (state_q == ST_IDLE) && valid_i && in_mem && !in_misal;

  mem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane (
    .op_i    (op_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .wdata_i (data_q),
    .rdata_i (ram_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LB;
      addr_q       <= '0;
      data_q       <= '0;
      waddr_q      <= '0;
      rwe_q        <= 1'b0;
      cnt_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_waddr_q   <= '0;
      wb_we_q      <= 1'b0;
      wb_wdata_q   <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      waddr_q      <= waddr_d;
      rwe_q        <= rwe_d;
      cnt_q        <= cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_we_q      <= wb_we_d;
      wb_wdata_q   <= wb_wdata_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_REQ;
      ST_REQ:  if (ram_gnt_i) state_d = is_store(op_q) ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (ram_rvalid_i || (cnt_q == CNT_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture registers and MEM/WB payload; a response wins over a same-cycle timeout.
  always_comb begin
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    waddr_d      = waddr_q;
    rwe_d        = rwe_q;
    cnt_d        = cnt_q;
    wb_valid_d   = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    wb_waddr_d   = wb_waddr_q;
    wb_we_d      = wb_we_q;
    wb_wdata_d   = wb_wdata_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && !in_mem) begin
          wb_valid_d = 1'b1;
          wb_waddr_d = reg_waddr_i;
          wb_we_d    = reg_we_i;
          wb_wdata_d = reg_wdata_i;
        end else if (valid_i && in_misal) begin
          wb_valid_d   = 1'b1;
          wb_waddr_d   = reg_waddr_i;
          wb_we_d      = 1'b0;
          misalign_d   = 1'b1;
          fault_addr_d = mem_addr_i;
        end else if (accept_c) begin
          op_d    = op_in;
          addr_d  = mem_addr_i;
          data_d  = mem_data_i;
          waddr_d = reg_waddr_i;
          rwe_d   = reg_we_i;
        end
      end
      ST_REQ: begin
        if (ram_gnt_i) begin
          cnt_d = '0;
          if (is_store(op_q)) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = waddr_q;
            wb_we_d    = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (ram_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          wb_we_d    = rwe_q;
          wb_wdata_d = load_data;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d   = 1'b1;
          wb_waddr_d   = waddr_q;
          wb_we_d      = 1'b0;
          bus_err_d    = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_o     = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if ((state_q != ST_IDLE) || accept_c) stall_o = 1'b1;
    if (state_q == ST_REQ) begin
      ram_req_o   = 1'b1;
      ram_we_o    = is_store(op_q);
      ram_addr_o  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      ram_be_o    = lane_be;
      ram_wdata_o = lane_wdata;
    end
  end

  assign wb_valid_o   = wb_valid_q;
  assign reg_waddr_o  = wb_waddr_q;
  assign reg_we_o     = wb_we_q;
  assign reg_wdata_o  = wb_wdata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;
  assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: 32- and 64-bit instances driven in lockstep, checked
// against a byte-arithmetic reference model.
module tb_mem_lsu;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [31:0] reg_wdata;
  logic        ram_gnt;
  logic        ram_rvalid;
  logic [63:0] rdata64;
  logic [31:0] rdata32;

  logic        d32_stall, d32_req, d32_we, d32_wbv, d32_rwe, d32_mis, d32_berr;
  logic [31:0] d32_addr, d32_wdata, d32_rwdata, d32_fault;
  logic [3:0]  d32_be;
  logic [4:0]  d32_rwaddr;
  logic        d64_stall, d64_req, d64_we, d64_wbv, d64_rwe, d64_mis, d64_berr;
  logic [31:0] d64_addr, d64_rwdata, d64_fault;
  logic [63:0] d64_wdata;
  logic [7:0]  d64_be;
  logic [4:0]  d64_rwaddr;

  int n_checks = 0;
  int n_errors = 0;

  // The 32-bit RAM returns the word of the 64-bit line selected by addr[2].
  assign rdata32 = mem_addr[2] ? rdata64[63:32] : rdata64[31:0];

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(TMO)) u_d32 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .mem_op_i(mem_op),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .reg_waddr_i(reg_waddr),
    .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .stall_o(d32_stall),
    .ram_req_o(d32_req), .ram_we_o(d32_we), .ram_addr_o(d32_addr),
    .ram_be_o(d32_be), .ram_wdata_o(d32_wdata), .ram_gnt_i(ram_gnt),
    .ram_rvalid_i(ram_rvalid), .ram_rdata_i(rdata32), .wb_valid_o(d32_wbv),
    .reg_waddr_o(d32_rwaddr), .reg_we_o(d32_rwe), .reg_wdata_o(d32_rwdata),
    .misalign_o(d32_mis), .bus_err_o(d32_berr), .fault_addr_o(d32_fault));

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(TMO)) u_d64 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .mem_op_i(mem_op),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .reg_waddr_i(reg_waddr),
    .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .stall_o(d64_stall),
    .ram_req_o(d64_req), .ram_we_o(d64_we), .ram_addr_o(d64_addr),
    .ram_be_o(d64_be), .ram_wdata_o(d64_wdata), .ram_gnt_i(ram_gnt),
    .ram_rvalid_i(ram_rvalid), .ram_rdata_i(rdata64), .wb_valid_o(d64_wbv),
    .reg_waddr_o(d64_rwaddr), .reg_we_o(d64_rwe), .reg_wdata_o(d64_rwdata),
    .misalign_o(d64_mis), .bus_err_o(d64_berr), .fault_addr_o(d64_fault));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [63:0] o32, input logic [63:0] o64,
                      input logic [63:0] exp);
    chk({tag, "/32"}, o32, exp);
    chk({tag, "/64"}, o64, exp);
  endtask

  // Reference model: access size in bytes is 1 << op_sz.
  function automatic int op_sz(input int op);
    case (op)
      1, 4, 6: return 1;
      2, 7:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic aligned(input int op, input logic [31:0] a);
    return (a & ((32'd1 << op_sz(op)) - 32'd1)) == 32'd0;
  endfunction

  function automatic logic [7:0] mask_of(input int op);
    return 8'((16'd1 << (16'd1 << op_sz(op))) - 16'd1);
  endfunction

  function automatic logic [63:0] model_wdata(input int op, input logic [31:0] d);
    case (op_sz(op))
      0:       return {8{d[7:0]}};
      1:       return {4{d[15:0]}};
      default: return {2{d}};
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] a, input logic [63:0] rd);
    logic [63:0] sh;
    sh = rd >> (8 * a[2:0]);
    case (op)
      0:       return 32'($signed(sh[7:0]));
      1:       return 32'($signed(sh[15:0]));
      2:       return sh[31:0];
      3:       return {24'd0, sh[7:0]};
      4:       return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] waddr, input logic rwe, input logic [31:0] rwdata,
                        input logic [63:0] rd, input int gnt_dly, input int rv_dly);
    logic is_mem, is_st, is_ld, ok, timed_out;
    logic [7:0] m;
    is_mem    = (op < 8);
    is_st     = (op >= 5) && (op <= 7);
    is_ld     = (op <= 4);
    ok        = is_mem && aligned(op, addr);
    timed_out = 1'b0;
    m         = mask_of(op);
    @(negedge clk);
    valid = 1'b1; mem_op = 4'(op); mem_addr = addr; mem_data = data;
    reg_waddr = waddr; reg_we = rwe; reg_wdata = rwdata;
    ram_gnt = 1'b0; ram_rvalid = 1'b0; rdata64 = rd;
    #1;
    chk2("stall_accept", d32_stall, d64_stall, ok);
    chk2("req_accept", d32_req, d64_req, 0);
    if (ok) begin
      for (int g = 0; g <= gnt_dly; g++) begin
        @(negedge clk);
        ram_gnt = (g == gnt_dly);
        #1;
        chk2("req_held", d32_req, d64_req, 1);
        chk2("stall_req", d32_stall, d64_stall, 1);
        chk2("ram_we", d32_we, d64_we, is_st);
        chk("ram_addr/32", d32_addr, addr & ~32'd3);
        chk("ram_addr/64", d64_addr, addr & ~32'd7);
        chk("ram_be/32", d32_be, 4'(m << addr[1:0]));
        chk("ram_be/64", d64_be, 8'(m << addr[2:0]));
        if (is_st) begin
          chk("ram_wdata/32", d32_wdata, model_wdata(op, data) & 64'hFFFF_FFFF);
          chk("ram_wdata/64", d64_wdata, model_wdata(op, data));
        end
      end
      if (is_ld) begin
        for (int r = 0; r < TMO; r++) begin
          @(negedge clk);
          ram_gnt = 1'b0;
          ram_rvalid = (r == rv_dly);
          #1;
          chk2("stall_wait", d32_stall, d64_stall, 1);
          chk2("req_wait", d32_req, d64_req, 0);
          if (r == rv_dly) break;
          if (r == TMO - 1) timed_out = 1'b1;
        end
      end
    end
    @(negedge clk);
    valid = 1'b0; ram_gnt = 1'b0; ram_rvalid = 1'b0;
    #1;
    chk2("wb_valid", d32_wbv, d64_wbv, 1);
    chk2("stall_wb", d32_stall, d64_stall, 0);
    chk2("wb_waddr", d32_rwaddr, d64_rwaddr, waddr);
    chk2("wb_we", d32_rwe, d64_rwe, (!is_mem || (is_ld && ok && !timed_out)) ? rwe : 1'b0);
    chk2("misalign", d32_mis, d64_mis, is_mem && !ok);
    chk2("bus_err", d32_berr, d64_berr, timed_out);
    if (!is_mem)
      chk2("wb_wdata_pass", d32_rwdata, d64_rwdata, rwdata);
    else if (is_ld && ok && !timed_out)
      chk2("wb_wdata_load", d32_rwdata, d64_rwdata, model_load(op, addr, rd));
    if ((is_mem && !ok) || timed_out)
      chk2("fault_addr", d32_fault, d64_fault, addr);
    @(negedge clk);
    #1;
    chk2("wb_pulse", d32_wbv, d64_wbv, 0);
    chk2("exc_pulse", d32_mis | d32_berr, d64_mis | d64_berr, 0);
  endtask

  task automatic reset_mid(input logic in_wait);
    @(negedge clk);
    valid = 1'b1; mem_op = in_wait ? 4'd2 : 4'd7; mem_addr = 32'h0000_0440;
    mem_data = $urandom; reg_waddr = 5'd9; reg_we = 1'b1;
    ram_gnt = 1'b0; ram_rvalid = 1'b0;
    @(negedge clk);
    ram_gnt = in_wait;
    #1;
    chk2("rm_req_before", d32_req, d64_req, 1);
    if (in_wait) begin
      @(negedge clk);
      ram_gnt = 1'b0;
      #1;
      chk2("rm_stall_wait", d32_stall, d64_stall, 1);
    end
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk2("rm_req_drop", d32_req, d64_req, 0);
    chk2("rm_stall_drop", d32_stall, d64_stall, 0);
    chk2("rm_wb_reset", d32_wbv, d64_wbv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ram_rvalid = 1'b1;
    @(negedge clk);
    ram_rvalid = 1'b0;
    #1;
    chk2("rm_late_rvalid", d32_wbv, d64_wbv, 0);
    chk2("rm_stall_after", d32_stall, d64_stall, 0);
    @(negedge clk);
    #1;
    chk2("rm_late_rvalid2", d32_wbv, d64_wbv, 0);
  endtask

  initial begin
    int op;
    logic [31:0] a;
    rst_n = 1'b0; valid = 1'b0; mem_op = 4'd8; mem_addr = '0; mem_data = '0;
    reg_waddr = '0; reg_we = 1'b0; reg_wdata = '0;
    ram_gnt = 1'b0; ram_rvalid = 1'b0; rdata64 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk2("rst_stall", d32_stall, d64_stall, 0);
    chk2("rst_req", d32_req | d32_we, d64_req | d64_we, 0);
    chk2("rst_ram_addr", d32_addr, d64_addr, 0);
    chk2("rst_be", d32_be, d64_be, 0);
    chk2("rst_wdata", d32_wdata, d64_wdata, 0);
    chk2("rst_wb", {d32_wbv, d32_rwe, d32_mis, d32_berr}, {d64_wbv, d64_rwe, d64_mis, d64_berr}, 0);
    chk2("rst_reg", {d32_rwaddr, d32_rwdata}, {d64_rwaddr, d64_rwdata}, 0);
    chk2("rst_fault", d32_fault, d64_fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8, 32'h0000_0300, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 64'h0, 0, 0);
    run_op(0, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h0, {32'hDEAD_BEEF, 32'h80FF_FF7F}, 0, 0);
    chk("lb_sign_const", d32_rwdata, 32'hFFFF_FF80);
    run_op(3, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h0, {32'hDEAD_BEEF, 32'h80FF_FF7F}, 1, 2);
    chk("lbu_zero_const", d64_rwdata, 32'h0000_0080);
    run_op(6, 32'h0000_0206, 32'h0000_ABCD, 5'd3, 1'b1, 32'h0, 64'h0, 3, 0);
    run_op(2, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 32'h0, 64'h0, 0, 0);
    run_op(2, 32'h0000_0500, 32'h0, 5'd6, 1'b1, 32'h0, {$urandom, $urandom}, 0, 100);
    @(negedge clk);
    ram_rvalid = 1'b1;
    @(negedge clk);
    ram_rvalid = 1'b0;
    #1;
    chk2("late_rvalid_ignored", d32_wbv, d64_wbv, 0);
    run_op(1, 32'h0000_0602, 32'h0, 5'd8, 1'b1, 32'h0, {$urandom, $urandom}, 0, TMO - 1);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 8));
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << op_sz(op)) - 32'd1);
      run_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit that succeeds the combinational MEM stage and sits between the EXE/MEM pipeline register and MEM/WB. Supports all RV32 load/store widths with sign/zero extension, drives the data RAM through a request/grant/response handshake with byte enables (no read-modify-write), stalls the pipeline while an access is outstanding, and flags misaligned accesses and RAM response timeouts. Non-memory instructions pass through with one cycle of registered latency.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, RAM data width; legal values 32 or 64
- RADDR_WIDTH, 5, register-file address width
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before bus error; legal range 1..65535

- clk_i  in  1  clock; one clock domain
- rst_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction present from EXE/MEM
- mem_op_i  in  4  LB, LH, LW, LBU, LHU, SB, SH, SW, NONE
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_data_i  in  32  store data, right-aligned
- reg_waddr_i / reg_we_i / reg_wdata_i  in  RADDR_WIDTH / 1 / 32  writeback info from EXE
- stall_o  out  1  upstream must hold all inputs while high
- ram_req_o / ram_we_o  out  1 / 1  request; write when 1
- ram_addr_o  out  ADDR_WIDTH  address aligned to DATA_WIDTH/8
- ram_be_o  out  DATA_WIDTH/8  byte enables
- ram_wdata_o  out  DATA_WIDTH  store data replicated into lane
- ram_gnt_i  in  1  request accepted
- ram_rvalid_i / ram_rdata_i  in  1 / DATA_WIDTH  read response
- wb_valid_o  out  1  MEM/WB contents valid
- reg_waddr_o / reg_we_o / reg_wdata_o  out  RADDR_WIDTH / 1 / 32  to MEM/WB
- misalign_o / bus_err_o  out  1 / 1  one-cycle exception pulses, aligned with wb_valid_o
- fault_addr_o  out  ADDR_WIDTH  faulting address, valid with either exception pulse

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, valid_i with mem_op NONE: register the passthrough to MEM/WB. No stall.
- IDLE, valid_i with load/store: check alignment. Halfword requires addr[0]=0. Word requires addr[1:0]=0.
  - Misaligned: no RAM access. Next cycle wb_valid_o=1, reg_we_o=0, misalign_o=1, fault_addr_o=addr.
  - Aligned: capture op, address, data and wb info; go to REQ. stall_o=1 combinationally in this cycle.
- Lane offset = addr[log2(DATA_WIDTH/8)-1:0].
  - ram_be_o: 1, 2 or 4 ones shifted by the offset.
  - ram_wdata_o: mem_data_i byte/half/word replicated across all lanes.
  - Loads: ram_be_o set the same way; ram_we_o=0.
- REQ: ram_req_o=1, inputs held stable until ram_gnt_i.
  - Store granted: finish (writeback with reg_we_o=0); return to IDLE.
  - Load granted: go to WAIT and clear the timeout counter.
- WAIT: counter increments each cycle.
  - On ram_rvalid_i: extract the byte/half/word at the lane offset, sign-extend (LB, LH) or zero-extend (LBU, LHU), write to reg_wdata_o, return to IDLE.
  - If the counter reaches TIMEOUT_CYCLES first: bus_err_o=1, reg_we_o=0, return to IDLE.
- Ignored inputs:
  - ram_rvalid_i outside WAIT.
  - ram_gnt_i outside REQ.
  - valid_i while stall_o=1 (upstream holds it).
- The RAM never asserts ram_rvalid_i in the same cycle as ram_gnt_i for that request.
- Reset in any state: immediate return to IDLE, ram_req_o drops. A late ram_rvalid_i after reset is dropped.

## Timing
- Reset values: all outputs 0, including stall_o, ram_*, wb_valid_o, reg_*, misalign_o, bus_err_o and fault_addr_o.
- All outputs are registered except stall_o, ram_req_o, ram_addr_o, ram_be_o, ram_wdata_o and ram_we_o, which are decoded from state and captured registers.
- Latencies, with a memory op accepted at cycle T:
  - Passthrough: wb_valid_o at T+1.
  - Store with gnt at T+1: wb at T+2.
  - Load with gnt at T+1 and rvalid at T+2: wb at T+3.
- stall_o: high from T through the cycle in which the final gnt/rvalid/timeout is observed. Low in the cycle wb_valid_o rises.
- wb_valid_o is a single-cycle pulse per instruction.

## Structure
- Package mem_pkg holds:
  - mem_op encoding: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7, NONE=8.
  - State enum.
  - Width constants.
- One sub-module, mem_lane_align: combinational byte-enable, store-replication and load-extract/extension logic, parametrised by DATA_WIDTH.

## Test plan
- Passthrough: NONE, reg_wdata_i=0x1234, waddr=5 -> wb_valid_o at T+1, reg_wdata_o=0x1234, stall_o never high.
- Load sign extension: LB at addr 0x103, rdata=0x80FF_FF7F (DATA_WIDTH=32) -> ram_be_o=1000, reg_wdata_o=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- Store at DATA_WIDTH=64: SH at addr 0x206, data 0xABCD, gnt delayed 3 cycles -> ram_be_o=0xC0, ram_addr_o=0x200, req held 3 cycles, reg_we_o=0.
- Misaligned: LW at 0x102 -> no ram_req_o, misalign_o=1, fault_addr_o=0x102 at T+1.
- Timeout: TIMEOUT_CYCLES=4, LW granted but rvalid never asserted -> bus_err_o after 4 WAIT cycles, state IDLE. A later rvalid is ignored.
- Reset mid-access: rst_n_i low in WAIT -> ram_req_o and stall_o drop immediately. An rvalid after reset release produces no wb_valid_o.
